clocking_skew_model: RTL and testbench

- Cycle-accurate, synthesizable clocking-block model for benches and simulators without native clocking-block support.
- Generalises the single-signal input/output skew emulation to CHANNELS independent lanes of WIDTH bits.
- Input skew and output skew are runtime-programmable, in whole clock cycles.
- The output path has a valid/ready drive handshake, per-channel drive masks, and safe skew reprogramming by draining pending drives.

---
 rtl/clocking_skew_model.sv | 225 ++++++++++++++++++++++
 tb/tb_clocking_skew_model.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clocking_skew_model.sv
// -----------------------------------------------------------------------------
// clocking_skew_model
//
// Cycle-accurate clocking-block emulation for CHANNELS lanes of WIDTH bits.
// The input side keeps a sample history of pin_in and presents the sample
// taken in_skew edges ago. The output side delays accepted drives by
// active_out_skew edges through a pending pipeline before they reach pin_out.
// A skew change first drains pending drives, so every drive lands with the
// skew it was accepted under.
//
// Parameters must satisfy MAX_IN_SKEW >= 1 and MAX_OUT_SKEW >= 1.
//
// Ports
//   clk              sampling clock, all activity on posedge
//   rst              synchronous active-high reset
//   in_skew          input skew in cycles; clamped to MAX_IN_SKEW
//   out_skew         requested output skew; clamped to MAX_OUT_SKEW
//   pin_in           DUT-side signals to sample
//   cb_in            skewed sampled view (combinational select of history)
//   cb_in_valid      history deep enough for the current in_skew
//   drv_valid        drive request
//   drv_ready        drive accepted when drv_valid && drv_ready
//   drv_data         drive values
//   drv_mask         per-lane drive enable
//   pin_out          driven DUT-side signals
//   busy             one or more drives pending
//   active_out_skew  output skew currently in effect
// -----------------------------------------------------------------------------
module clocking_skew_model #(
    parameter int              WIDTH        = 8,
    parameter int              CHANNELS     = 2,
    parameter int              MAX_IN_SKEW  = 4,
    parameter int              MAX_OUT_SKEW = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(MAX_IN_SKEW+1)-1:0]    in_skew,
    input  logic [$clog2(MAX_OUT_SKEW+1)-1:0]   out_skew,
    input  logic [CHANNELS*WIDTH-1:0]           pin_in,
    output logic [CHANNELS*WIDTH-1:0]           cb_in,
    output logic                                cb_in_valid,
    input  logic                                drv_valid,
    output logic                                drv_ready,
    input  logic [CHANNELS*WIDTH-1:0]           drv_data,
    input  logic [CHANNELS-1:0]                 drv_mask,
    output logic [CHANNELS*WIDTH-1:0]           pin_out,
    output logic                                busy,
    output logic [$clog2(MAX_OUT_SKEW+1)-1:0]   active_out_skew
);

    localparam int IN_SKW  = $clog2(MAX_IN_SKEW + 1);
    localparam int OUT_SKW = $clog2(MAX_OUT_SKEW + 1);
    localparam int DW      = CHANNELS * WIDTH;
    // Fill counter must be able to hold MAX_IN_SKEW+1.
    localparam int FILL_W  = $clog2(MAX_IN_SKEW + 2);

    // -------------------------------------------------------------------------
    // Input path
    // -------------------------------------------------------------------------
    logic [IN_SKW-1:0] w_in_skew_c;
    logic [DW-1:0]     r_hist [0:MAX_IN_SKEW];
    logic [IN_SKW-1:0] r_in_skew;
    logic [FILL_W-1:0] r_fill;

    assign w_in_skew_c = (in_skew > IN_SKW'(MAX_IN_SKEW)) ? IN_SKW'(MAX_IN_SKEW) : in_skew;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MAX_IN_SKEW; i++) begin
                r_hist[i] <= '0;
            end
            r_fill    <= '0;
            r_in_skew <= w_in_skew_c;
        end else begin
            r_hist[0] <= pin_in;
            for (int i = 1; i <= MAX_IN_SKEW; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_in_skew <= w_in_skew_c;
            // A skew change keeps the history but restarts the fill count:
            // only the sample taken on this edge is trusted afterwards.
            if (w_in_skew_c != r_in_skew) begin
                r_fill <= FILL_W'(1);
            end else if (r_fill != FILL_W'(MAX_IN_SKEW + 1)) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    assign cb_in       = r_hist[w_in_skew_c];
    assign cb_in_valid = (r_fill > FILL_W'(w_in_skew_c));

    // -------------------------------------------------------------------------
    // Output-skew control FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic [OUT_SKW-1:0] r_active_out_skew;
    logic [OUT_SKW-1:0] w_out_skew_c;
    logic               w_accept;
    logic               w_busy;

    assign w_out_skew_c = (out_skew > OUT_SKW'(MAX_OUT_SKEW)) ? OUT_SKW'(MAX_OUT_SKEW) : out_skew;

    // r_ready is registered from the next state; rst masks it combinationally
    // so no drive can be accepted while reset is held.
    assign drv_ready = r_ready & ~rst;
    assign w_accept  = drv_valid & drv_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_RUN;
            r_ready           <= 1'b1;
            r_active_out_skew <= w_out_skew_c;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A drive offered on this edge is still taken at the old skew.
                    if (w_out_skew_c != r_active_out_skew) begin
                        r_state <= ST_DRAIN;
                        r_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!w_busy) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_active_out_skew <= w_out_skew_c;
                    r_state           <= ST_RUN;
                    r_ready           <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pending pipeline: stage 0 lands on the next edge. A drive accepted with
    // skew s enters stage s-1, so it reaches pin_out exactly s edges later.
    // Stages above s-1 are always empty while the skew is stable, so the
    // insert never collides with a shifting entry.
    // -------------------------------------------------------------------------
    logic [MAX_OUT_SKEW-1:0]                w_pv;
    logic [MAX_OUT_SKEW-1:0][CHANNELS-1:0]  w_pm;
    logic [MAX_OUT_SKEW-1:0][DW-1:0]        w_pd;

    genvar gi;
    for (gi = 0; gi < MAX_OUT_SKEW; gi++) begin : g_stage
        logic                r_pv;
        logic [CHANNELS-1:0] r_pm;
        logic [DW-1:0]       r_pd;
        logic                w_up_v;
        logic [CHANNELS-1:0] w_up_m;
        logic [DW-1:0]       w_up_d;

        if (gi == MAX_OUT_SKEW - 1) begin : g_tail
            assign w_up_v = 1'b0;
            assign w_up_m = '0;
            assign w_up_d = '0;
        end else begin : g_body
            assign w_up_v = w_pv[gi+1];
            assign w_up_m = w_pm[gi+1];
            assign w_up_d = w_pd[gi+1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pv <= 1'b0;
                r_pm <= '0;
                r_pd <= '0;
            end else if (w_accept && (r_active_out_skew == OUT_SKW'(gi + 1))) begin
                r_pv <= 1'b1;
                r_pm <= drv_mask;
                r_pd <= drv_data;
            end else begin
                r_pv <= w_up_v;
                r_pm <= w_up_m;
                r_pd <= w_up_d;
            end
        end

        assign w_pv[gi] = r_pv;
        assign w_pm[gi] = r_pm;
        assign w_pd[gi] = r_pd;
    end

    assign w_busy = |w_pv;
    assign busy   = w_busy;

    // -------------------------------------------------------------------------
    // Output lanes: a zero-skew drive and a landing stage-0 entry cannot occur
    // on the same edge (skew 0 implies an empty pipeline), so each lane has a
    // single effective writer.
    // -------------------------------------------------------------------------
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic [WIDTH-1:0] r_lane;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_lane <= RESET_VAL;
            end else if (w_accept && (r_active_out_skew == '0) && drv_mask[gi]) begin
                r_lane <= drv_data[gi*WIDTH +: WIDTH];
            end else if (w_pv[0] && w_pm[0][gi]) begin
                r_lane <= w_pd[0][gi*WIDTH +: WIDTH];
            end
        end

        assign pin_out[gi*WIDTH +: WIDTH] = r_lane;
    end

    assign active_out_skew = r_active_out_skew;

endmodule

// File: tb/tb_clocking_skew_model.sv
// -----------------------------------------------------------------------------
// tb_clocking_skew_model
//
// Directed bench for clocking_skew_model (WIDTH=8, CHANNELS=2, max skews 4,
// RESET_VAL=8'hA5). Input-path and output-path behaviour are driven from two
// tables of hand-computed vectors; clamp and mid-flight reset are a short
// hand-written sequence. Inputs change #1 after posedge, outputs are checked
// #1 after posedge.
// -----------------------------------------------------------------------------
module tb_clocking_skew_model;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_skew;
    logic [2:0]  out_skew;
    logic [15:0] pin_in;
    logic [15:0] cb_in;
    logic        cb_in_valid;
    logic        drv_valid;
    logic        drv_ready;
    logic [15:0] drv_data;
    logic [1:0]  drv_mask;
    logic [15:0] pin_out;
    logic        busy;
    logic [2:0]  active_out_skew;

    int n_checks = 0;
    int n_errors = 0;

    clocking_skew_model #(
        .WIDTH        (8),
        .CHANNELS     (2),
        .MAX_IN_SKEW  (4),
        .MAX_OUT_SKEW (4),
        .RESET_VAL    (8'hA5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_skew         (in_skew),
        .out_skew        (out_skew),
        .pin_in          (pin_in),
        .cb_in           (cb_in),
        .cb_in_valid     (cb_in_valid),
        .drv_valid       (drv_valid),
        .drv_ready       (drv_ready),
        .drv_data        (drv_data),
        .drv_mask        (drv_mask),
        .pin_out         (pin_out),
        .busy            (busy),
        .active_out_skew (active_out_skew)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  in_skew;
        logic [15:0] pin;
        logic [15:0] exp_cb;
        logic        exp_valid;
    } in_vec_t;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic [1:0]  mask;
        logic [2:0]  oskew;
        logic [15:0] exp_pin;
        logic        exp_ready;
        logic        exp_busy;
        logic [2:0]  exp_active;
    } out_vec_t;

    in_vec_t  in_tab  [13];
    out_vec_t out_tab [24];

    // Ramp value v on the lower lane and v+0x10 on the upper lane.
    function automatic logic [15:0] mk(input int v);
        return {8'(v + 16), 8'(v)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Input path, in_skew=3 from reset; edge k samples ramp value k+1.
        in_tab[0]  = '{3'd3, mk(1),  16'h0000, 1'b0};
        in_tab[1]  = '{3'd3, mk(2),  16'h0000, 1'b0};
        in_tab[2]  = '{3'd3, mk(3),  16'h0000, 1'b0};
        in_tab[3]  = '{3'd3, mk(4),  mk(1),    1'b1};
        in_tab[4]  = '{3'd3, mk(5),  mk(2),    1'b1};
        in_tab[5]  = '{3'd3, mk(6),  mk(3),    1'b1};
        in_tab[6]  = '{3'd3, mk(7),  mk(4),    1'b1};
        in_tab[7]  = '{3'd3, mk(8),  mk(5),    1'b1};
        // switch to skew 1: one edge invalid, then 2-edge latency
        in_tab[8]  = '{3'd1, mk(9),  mk(8),    1'b0};
        in_tab[9]  = '{3'd1, mk(10), mk(9),    1'b1};
        in_tab[10] = '{3'd1, mk(11), mk(10),   1'b1};
        // skew 7 clamps to 4: refill restarts, deepest history selected
        in_tab[11] = '{3'd7, mk(12), mk(8),    1'b0};
        in_tab[12] = '{3'd7, mk(13), mk(9),    1'b0};

        // Output path, starting at active skew 2 with pin_out=A5A5.
        out_tab[0]  = '{1'b1, 16'h0101, 2'b11, 3'd2, 16'hA5A5, 1'b1, 1'b1, 3'd2};
        out_tab[1]  = '{1'b1, 16'h0202, 2'b11, 3'd2, 16'hA5A5, 1'b1, 1'b1, 3'd2};
        out_tab[2]  = '{1'b0, 16'h0000, 2'b11, 3'd2, 16'h0101, 1'b1, 1'b1, 3'd2};
        out_tab[3]  = '{1'b0, 16'h0000, 2'b11, 3'd2, 16'h0202, 1'b1, 1'b0, 3'd2};
        // change to skew 0: DRAIN, LOAD, RUN
        out_tab[4]  = '{1'b0, 16'h0000, 2'b11, 3'd0, 16'h0202, 1'b0, 1'b0, 3'd2};
        out_tab[5]  = '{1'b0, 16'h0000, 2'b11, 3'd0, 16'h0202, 1'b0, 1'b0, 3'd2};
        out_tab[6]  = '{1'b0, 16'h0000, 2'b11, 3'd0, 16'h0202, 1'b1, 1'b0, 3'd0};
        // skew 0 with masks
        out_tab[7]  = '{1'b1, 16'h0000, 2'b11, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0};
        out_tab[8]  = '{1'b1, 16'hAA55, 2'b01, 3'd0, 16'h0055, 1'b1, 1'b0, 3'd0};
        out_tab[9]  = '{1'b1, 16'hBBCC, 2'b10, 3'd0, 16'hBB55, 1'b1, 1'b0, 3'd0};
        // change to skew 4
        out_tab[10] = '{1'b0, 16'h0000, 2'b11, 3'd4, 16'hBB55, 1'b0, 1'b0, 3'd0};
        out_tab[11] = '{1'b0, 16'h0000, 2'b11, 3'd4, 16'hBB55, 1'b0, 1'b0, 3'd0};
        out_tab[12] = '{1'b0, 16'h0000, 2'b11, 3'd4, 16'hBB55, 1'b1, 1'b0, 3'd4};
        // three drives at skew 4; request skew 1 with the third
        out_tab[13] = '{1'b1, 16'h1111, 2'b11, 3'd4, 16'hBB55, 1'b1, 1'b1, 3'd4};
        out_tab[14] = '{1'b1, 16'h2222, 2'b11, 3'd4, 16'hBB55, 1'b1, 1'b1, 3'd4};
        out_tab[15] = '{1'b1, 16'h3333, 2'b11, 3'd1, 16'hBB55, 1'b0, 1'b1, 3'd4};
        // 0x4444 offered throughout the drain; must not be taken until RUN
        out_tab[16] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'hBB55, 1'b0, 1'b1, 3'd4};
        out_tab[17] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'h1111, 1'b0, 1'b1, 3'd4};
        out_tab[18] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'h2222, 1'b0, 1'b1, 3'd4};
        out_tab[19] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'h3333, 1'b0, 1'b0, 3'd4};
        out_tab[20] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'h3333, 1'b0, 1'b0, 3'd4};
        out_tab[21] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'h3333, 1'b1, 1'b0, 3'd1};
        out_tab[22] = '{1'b1, 16'h4444, 2'b11, 3'd1, 16'h3333, 1'b1, 1'b1, 3'd1};
        out_tab[23] = '{1'b0, 16'h0000, 2'b11, 3'd1, 16'h4444, 1'b1, 1'b0, 3'd1};

        // ---------------- reset with a drive offered ----------------
        rst       = 1'b1;
        in_skew   = 3'd3;
        out_skew  = 3'd2;
        pin_in    = 16'h0000;
        drv_valid = 1'b1;
        drv_data  = 16'hFFFF;
        drv_mask  = 2'b11;
        tick();
        tick();
        $display("reset: pin_out=%h cb_in=%h cb_in_valid=%b drv_ready=%b busy=%b active=%0d",
                 pin_out, cb_in, cb_in_valid, drv_ready, busy, active_out_skew);
        check("reset_pin_out",   32'(pin_out),         32'h0000A5A5);
        check("reset_cb_in",     32'(cb_in),           32'h0);
        check("reset_cb_valid",  32'(cb_in_valid),     32'h0);
        check("reset_drv_ready", 32'(drv_ready),       32'h0);
        check("reset_busy",      32'(busy),            32'h0);
        check("reset_active",    32'(active_out_skew), 32'd2);
        rst       = 1'b0;
        drv_valid = 1'b0;

        // ---------------- input path table ----------------
        for (int i = 0; i < 13; i++) begin
            in_skew = in_tab[i].in_skew;
            pin_in  = in_tab[i].pin;
            tick();
            $display("in  row %0d: in_skew=%0d pin_in=%h cb_in=%h cb_in_valid=%b",
                     i, in_skew, pin_in, cb_in, cb_in_valid);
            check($sformatf("in_row%0d_cb_in", i),       32'(cb_in),       32'(in_tab[i].exp_cb));
            check($sformatf("in_row%0d_cb_in_valid", i), 32'(cb_in_valid), 32'(in_tab[i].exp_valid));
        end

        // ---------------- output path table ----------------
        for (int i = 0; i < 24; i++) begin
            drv_valid = out_tab[i].valid;
            drv_data  = out_tab[i].data;
            drv_mask  = out_tab[i].mask;
            out_skew  = out_tab[i].oskew;
            tick();
            $display("out row %0d: valid=%b data=%h mask=%b out_skew=%0d -> pin_out=%h ready=%b busy=%b active=%0d",
                     i, drv_valid, drv_data, drv_mask, out_skew, pin_out, drv_ready, busy, active_out_skew);
            check($sformatf("out_row%0d_pin_out", i), 32'(pin_out),         32'(out_tab[i].exp_pin));
            check($sformatf("out_row%0d_ready", i),   32'(drv_ready),       32'(out_tab[i].exp_ready));
            check($sformatf("out_row%0d_busy", i),    32'(busy),            32'(out_tab[i].exp_busy));
            check($sformatf("out_row%0d_active", i),  32'(active_out_skew), 32'(out_tab[i].exp_active));
        end

        // ---------------- clamp and reset mid-flight ----------------
        drv_valid = 1'b0;
        out_skew  = 3'd7;
        tick();
        check("clamp_drain_ready", 32'(drv_ready), 32'h0);
        tick();
        tick();
        $display("clamp: out_skew=%0d active=%0d ready=%b", out_skew, active_out_skew, drv_ready);
        check("clamp_active", 32'(active_out_skew), 32'd4);
        check("clamp_ready",  32'(drv_ready),       32'h1);

        drv_valid = 1'b1;
        drv_data  = 16'h7777;
        drv_mask  = 2'b11;
        tick();
        $display("flight: drive %h accepted, busy=%b", drv_data, busy);
        check("flight_busy", 32'(busy), 32'h1);
        drv_valid = 1'b0;
        tick();
        check("flight_pin_hold", 32'(pin_out), 32'h4444);
        rst = 1'b1;
        tick();
        $display("flight reset: pin_out=%h busy=%b ready=%b active=%0d", pin_out, busy, drv_ready, active_out_skew);
        check("flight_rst_pin",    32'(pin_out),         32'h0000A5A5);
        check("flight_rst_busy",   32'(busy),            32'h0);
        check("flight_rst_ready",  32'(drv_ready),       32'h0);
        check("flight_rst_active", 32'(active_out_skew), 32'd4);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            $display("post reset %0d: pin_out=%h busy=%b", k, pin_out, busy);
            check($sformatf("post_rst%0d_pin", k),  32'(pin_out), 32'h0000A5A5);
            check($sformatf("post_rst%0d_busy", k), 32'(busy),    32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
